// File: rtl/baseband_rx_pkg.sv
// Shared types, constants and the per-axis slicer for the receive demapper.
package baseband_rx_pkg;

  // Mapping selector values
  localparam logic MAP_QPSK  = 1'b0;
  localparam logic MAP_QAM16 = 1'b1;

  // Bits carried by one symbol in each mapping
  localparam int BITS_QPSK  = 2;
  localparam int BITS_QAM16 = 4;

  // FIFO entry: {mapping, I bits[1:0], Q bits[1:0]}
  localparam int ENTRY_W = 5;

  typedef struct packed {
    logic       map;
    logic [1:0] i_bits;
    logic [1:0] q_bits;
  } sym_entry_t;

  // Serializer state encoding
  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  // Gray-coded decision for one axis. QPSK uses bit[0] only; bit[1] is 0.
  // The sample is widened to int so -512 and +511 compare exactly.
  function automatic logic [1:0] slice_axis(input logic signed [9:0] v,
                                            input logic map,
                                            input int thresh);
    int x;
    x = int'(v);
    if (map == MAP_QPSK) begin
      slice_axis = {1'b0, (x >= 0)};
    end else if (x < -thresh) begin
      slice_axis = 2'b00;
    end else if (x < 0) begin
      slice_axis = 2'b01;
    end else if (x < thresh) begin
      slice_axis = 2'b11;
    end else begin
      slice_axis = 2'b10;
    end
  endfunction

endpackage

// File: rtl/rx_symbol_fifo.sv
// Synchronous DEPTHxWIDTH symbol FIFO with show-ahead read data.
// A push while full is accepted only when a pop happens in the same cycle.
module rx_symbol_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/baseband_demap.sv
// Receive demapper: decimate I/Q to one sample per symbol, slice to QPSK or
// 16-QAM Gray bits, buffer symbols, and serialize bits under valid/ready.
// Handshake: a bit is transferred on a cycle where data_valid && data_ready;
// data_out/data_valid stay stable while data_ready is low.
module baseband_demap
  import baseband_rx_pkg::*;
#(
  parameter int THRESH = 128,
  parameter int DEPTH  = 4
) (
  input  logic       dsp_clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       mapping,
  input  logic [3:0] sample_rate,
  input  logic [3:0] sample_phase,
  input  logic [9:0] I_in,
  input  logic [9:0] Q_in,
  input  logic       sample_valid,
  input  logic       data_ready,
  input  logic       overflow_clr,
  output logic       data_out,
  output logic       data_valid,
  output logic       overflow
);

  localparam int FIFO_AW = $clog2(DEPTH);

  // ---------------- decimator ----------------
  logic [3:0] w_n;
  logic [3:0] w_phase;
  logic [3:0] r_phase_cnt;
  logic       w_capture;

  // Effective symbol length and clamped phase
  always_comb begin
    w_n       = (sample_rate <= 4'd1) ? 4'd1 : sample_rate;
    w_phase   = (sample_phase >= w_n) ? (w_n - 4'd1) : sample_phase;
    w_capture = enable && sample_valid && (r_phase_cnt == w_phase);
  end

  // Phase counter: held at 0 while disabled, wraps at N-1
  always_ff @(posedge dsp_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase_cnt <= '0;
    end else if (!enable) begin
      r_phase_cnt <= '0;
    end else if (sample_valid) begin
      r_phase_cnt <= (r_phase_cnt >= (w_n - 4'd1)) ? 4'd0 : (r_phase_cnt + 4'd1);
    end
  end

  // ---------------- slicer ----------------
  logic       r_slc_valid;
  sym_entry_t r_slc_entry;

  // One registered slicing stage; mapping is latched with the sample
  always_ff @(posedge dsp_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slc_valid <= 1'b0;
      r_slc_entry <= '0;
    end else begin
      r_slc_valid <= w_capture;
      if (w_capture) begin
        r_slc_entry <= {mapping,
                        slice_axis($signed(I_in), mapping, THRESH),
                        slice_axis($signed(Q_in), mapping, THRESH)};
      end
    end
  end

  // ---------------- symbol FIFO ----------------
  logic [ENTRY_W-1:0] w_fifo_rdata;
  sym_entry_t         w_head;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [FIFO_AW:0]   w_fifo_count;
  logic               w_pop;
  logic               w_drop;

  rx_symbol_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_clk   (dsp_clk),
    .i_rst_n (rst_n),
    .i_push  (r_slc_valid),
    .i_wdata (r_slc_entry),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_head = w_fifo_rdata;
  assign w_drop = r_slc_valid && w_fifo_full && !w_pop;

  // Occupancy can never exceed the configured depth
  always_ff @(posedge dsp_clk) begin
    if (rst_n) assert (int'(w_fifo_count) <= DEPTH);
  end

  // ---------------- serializer ----------------
  ser_state_t r_state;
  ser_state_t w_next;
  logic [3:0] r_shift;
  logic [2:0] r_left;
  logic [3:0] w_load_bits;
  logic [2:0] w_load_len;
  logic       w_fire;
  logic       w_last;
  logic       w_adv;

  assign data_valid = (r_state == SER_SHIFT);
  assign data_out   = data_valid & r_shift[3];
  assign w_fire     = data_valid && data_ready;
  assign w_last     = (r_left == 3'd1);

  // Head entry laid out MSB-first: I MSB, I LSB, Q MSB, Q LSB (QPSK: I, Q)
  always_comb begin
    if (w_head.map == MAP_QAM16) begin
      w_load_bits = {w_head.i_bits, w_head.q_bits};
      w_load_len  = 3'(BITS_QAM16);
    end else begin
      w_load_bits = {w_head.i_bits[0], w_head.q_bits[0], 2'b00};
      w_load_len  = 3'(BITS_QPSK);
    end
  end

  // Serializer state register
  always_ff @(posedge dsp_clk or negedge rst_n) begin
    if (!rst_n) r_state <= SER_IDLE;
    else        r_state <= w_next;
  end

  // Next state, FIFO pop and shift control; the last bit's acceptance
  // chains straight into the next entry so symbols stream without a bubble
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_adv  = 1'b0;
    case (r_state)
      SER_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop  = 1'b1;
          w_next = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (w_fire) begin
          if (w_last) begin
            if (!w_fifo_empty) w_pop  = 1'b1;
            else               w_next = SER_IDLE;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      default: w_next = SER_IDLE;
    endcase
  end

  // Shift register and remaining-bit count
  always_ff @(posedge dsp_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_left  <= '0;
    end else if (w_pop) begin
      r_shift <= w_load_bits;
      r_left  <= w_load_len;
    end else if (w_adv) begin
      r_shift <= {r_shift[2:0], 1'b0};
      r_left  <= r_left - 3'd1;
    end
  end

  // ---------------- overflow ----------------
  logic r_overflow;
  assign overflow = r_overflow;

  // Sticky drop flag; a set in the same cycle as a clear wins
  always_ff @(posedge dsp_clk or negedge rst_n) begin
    if (!rst_n)            r_overflow <= 1'b0;
    else if (w_drop)       r_overflow <= 1'b1;
    else if (overflow_clr) r_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_baseband_demap.sv
// Directed bench for baseband_demap with a bit-stream scoreboard.
module tb_baseband_demap;

  localparam int TB_THRESH = 128;
  localparam int TB_DEPTH  = 4;

  logic       dsp_clk;
  logic       rst_n;
  logic       enable;
  logic       mapping;
  logic [3:0] sample_rate;
  logic [3:0] sample_phase;
  logic [9:0] I_in;
  logic [9:0] Q_in;
  logic       sample_valid;
  logic       data_ready;
  logic       overflow_clr;
  logic       data_out;
  logic       data_valid;
  logic       overflow;

  logic [0:0] exp_q[$];
  logic       e_bit;
  int         n_tests;
  int         n_fail;

  baseband_demap #(
    .THRESH (TB_THRESH),
    .DEPTH  (TB_DEPTH)
  ) dut (
    .dsp_clk      (dsp_clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .mapping      (mapping),
    .sample_rate  (sample_rate),
    .sample_phase (sample_phase),
    .I_in         (I_in),
    .Q_in         (Q_in),
    .sample_valid (sample_valid),
    .data_ready   (data_ready),
    .overflow_clr (overflow_clr),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .overflow     (overflow)
  );

  // ---------------- clock ----------------
  initial dsp_clk = 1'b0;
  always #5 dsp_clk = ~dsp_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge dsp_clk);
    #1;
  endtask

  task automatic neg();
    @(negedge dsp_clk);
  endtask

  // Queue n bits, MSB-first from b[3]
  task automatic push_bits(input logic [3:0] b, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(b[3-k]);
  endtask

  task automatic sample(input int i, input int q);
    I_in         = 10'(i);
    Q_in         = 10'(q);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 500) begin
      tick();
      cyc++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    repeat (3) tick();
    check({tag, "_idle"}, data_valid, 1'b0);
  endtask

  // Independent 16-QAM decision model from the decision regions
  function automatic logic [1:0] m_slice(input int v);
    if (v < -TB_THRESH) return 2'b00;
    if (v < 0)          return 2'b01;
    if (v < TB_THRESH)  return 2'b11;
    return 2'b10;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge dsp_clk) begin
    if (rst_n && data_valid && data_ready) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_bit: observed %0b expected none", data_out);
      end
      if (exp_q.size() != 0) begin
        e_bit = exp_q.pop_front();
        check("stream_bit", data_out, e_bit);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    enable       = 1'b0;
    mapping      = 1'b0;
    sample_rate  = 4'd1;
    sample_phase = 4'd0;
    I_in         = '0;
    Q_in         = '0;
    sample_valid = 1'b0;
    data_ready   = 1'b1;
    overflow_clr = 1'b0;

    // Reset values
    #12;
    check("rst_data_out", data_out, 1'b0);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    tick();
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();

    // QPSK, N=1: bits 1,0 and first bit valid two edges after capture
    mapping = 1'b0;
    push_bits(4'b1000, 2);
    sample(200, -200);
    neg(); check("qpsk_lat_e0", data_valid, 1'b0);
    neg(); check("qpsk_lat_e1", data_valid, 1'b0);
    neg(); check("qpsk_lat_e2", data_valid, 1'b1);
    wait_drain("qpsk");

    // 16-QAM directed points including the extreme codes
    mapping = 1'b1;
    push_bits(4'b0011, 4); sample(-300, 50);
    push_bits(4'b0110, 4); sample(-128, 128);
    push_bits(4'b0010, 4); sample(-512, 511);
    wait_drain("qam16");

    // Decimation N=4, phase 2: samples 2, 6, 10 of a ramp
    sample_rate  = 4'd4;
    sample_phase = 4'd2;
    for (int k = 0; k < 12; k++) begin
      if (k % 4 == 2) push_bits({m_slice(60*k - 300), m_slice(0)}, 4);
      sample(60*k - 300, 0);
    end
    wait_drain("decim_p2");

    // Phase 7 clamps to 3: samples 3, 7, 11
    sample_phase = 4'd7;
    for (int k = 0; k < 12; k++) begin
      if (k % 4 == 3) push_bits({m_slice(60*k - 300), m_slice(0)}, 4);
      sample(60*k - 300, 0);
    end
    wait_drain("decim_p7");

    // Disabled: nothing is captured
    enable = 1'b0;
    sample(300, 300);
    sample(-300, -300);
    sample(100, 100);
    repeat (6) tick();
    check("disabled_no_output", data_valid, 1'b0);
    enable       = 1'b1;
    sample_rate  = 4'd1;
    sample_phase = 4'd0;

    // Mapping switch: QPSK then 16-QAM, six contiguous valid cycles
    mapping = 1'b0;
    push_bits(4'b1100, 2);
    sample(200, 200);
    mapping = 1'b1;
    push_bits(4'b0000, 4);
    sample(-300, -300);
    neg(); check("switch_pre", data_valid, 1'b0);
    neg(); check("switch_first", data_valid, 1'b1);
    for (int j = 0; j < 5; j++) begin
      neg(); check("switch_no_bubble", data_valid, 1'b1);
    end
    neg(); check("switch_end", data_valid, 1'b0);
    wait_drain("switch");

    // Backpressure: six symbols with ready low, sixth is dropped
    data_ready = 1'b0;
    mapping    = 1'b1;
    push_bits(4'b1000, 4); sample(300, -300);
    push_bits(4'b0110, 4); sample(-128, 128);
    push_bits(4'b0011, 4); sample(-300, 50);
    push_bits(4'b1101, 4); sample(100, -100);
    push_bits(4'b0010, 4); sample(-512, 511);
    sample(200, 200);
    neg(); check("bp_ovf_before_drop", overflow, 1'b0);
    for (int c = 0; c < 14; c++) begin
      neg();
      check("bp_valid_held", data_valid, 1'b1);
      check("bp_data_held", data_out, 1'b1);
    end
    check("bp_overflow_set", overflow, 1'b1);
    tick();
    check("bp_overflow_sticky", overflow, 1'b1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    neg(); check("bp_overflow_cleared", overflow, 1'b0);
    tick();
    data_ready = 1'b1;
    wait_drain("backpressure");

    // Reset after two of four bits
    push_bits(4'b0011, 4);
    sample(-300, 50);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_valid", data_valid, 1'b0);
    check("midrst_data", data_out, 1'b0);
    check("midrst_bits_left", exp_q.size(), 2);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    push_bits(4'b0110, 4);
    sample(-128, 128);
    neg(); check("postrst_lat_e0", data_valid, 1'b0);
    neg(); check("postrst_lat_e1", data_valid, 1'b0);
    neg(); check("postrst_lat_e2", data_valid, 1'b1);
    wait_drain("postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
